// File: rtl/excp_ctrl.sv
// Exception tracking and redirect control. Tags instructions with IF/ID/EX
// exception flags, carries them down an ID/EX/WB record pipe, presents the
// packed vector at WB, and holds a redirect to fetch after a taken exception
// or ERTN until fetch accepts it.
module excp_ctrl #(
    parameter int VEC_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             stallreq_axi,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic             if_adef,
    input  logic             id_ine,
    input  logic             id_priv,
    input  logic             id_syscall,
    input  logic             id_break,
    input  logic             id_ertn,
    input  logic             ex_ale,
    input  logic [31:0]      ex_va,
    input  logic             has_int_in,
    input  logic [1:0]       plv_in,
    input  logic             except_en,
    input  logic [31:0]      new_pc,
    output logic             wb_valid,
    output logic [VEC_W-1:0] wb_csr_vec,
    output logic [31:0]      wb_pc,
    output logic [31:0]      wb_error_va,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready
);

    // Flag bit layout: {ale, adef, ipe, ine, break, syscall, ertn, int}
    typedef enum logic {RUN, REDIR} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        advance;
    logic        wb_hold;
    logic        ale_take;
    logic [7:0]  wb_vec8;

    logic        vld_p0, vld_p1, vld_p2;
    logic [31:0] pc_p0, pc_p1, pc_p2;
    logic [7:0]  flg_p0, flg_p1, flg_p2;
    logic [31:0] va_p0, va_p1, va_p2;

    // Decode-stage flags are suppressed once a fetch error already owns the record.
    function automatic logic [7:0] merge_id_flags(
        input logic [7:0] flg,
        input logic       ine,
        input logic       priv,
        input logic [1:0] plv,
        input logic       sys,
        input logic       brk,
        input logic       ertn
    );
        logic [7:0] res;
        res = flg;
        if (!flg[6]) begin
            res[4] = ine;
            res[5] = priv && (plv != 2'd0);
            res[2] = sys;
            res[3] = brk;
            res[1] = ertn;
        end
        return res;
    endfunction

    // Interrupt may ride along with any other flag; ALE only on a clean record.
    function automatic logic [7:0] merge_ex_flags(
        input logic [7:0] flg,
        input logic       ale,
        input logic       intr
    );
        logic [7:0] res;
        res    = flg;
        res[7] = ale;
        res[0] = intr;
        return res;
    endfunction

    assign wb_vec8  = vld_p2 ? flg_p2 : 8'd0;
    assign wb_hold  = (wb_vec8 != 8'd0) && !accept;
    assign advance  = !stall && (state == RUN) && !wb_hold;
    assign ale_take = vld_p1 && ex_ale && (flg_p1 == 8'd0);

    assign wb_valid    = vld_p2;
    assign wb_csr_vec  = {{(VEC_W-8){1'b0}}, wb_vec8};
    assign wb_pc       = pc_p2;
    assign wb_error_va = va_p2;

    // State register for the redirect FSM.
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // Next state, commit acceptance, flush and redirect request.
    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        case (state)
            RUN: begin
                if (except_en && !stallreq_axi) begin
                    accept    = 1'b1;
                    flush     = 1'b1;
                    state_nxt = REDIR;
                end
            end
            REDIR: begin
                redirect_valid = 1'b1;
                flush          = 1'b1;
                if (redirect_ready) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Redirect target is latched only at acceptance, so it is stable in REDIR.
    always_ff @(posedge clk) begin
        if (reset)       redirect_pc <= 32'd0;
        else if (accept) redirect_pc <= new_pc;
    end

    // ID/EX/WB record pipe: flush on commit, otherwise advance or hold.
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            vld_p0 <= 1'b0;  pc_p0 <= 32'd0;  flg_p0 <= 8'd0;  va_p0 <= 32'd0;
            vld_p1 <= 1'b0;  pc_p1 <= 32'd0;  flg_p1 <= 8'd0;  va_p1 <= 32'd0;
            vld_p2 <= 1'b0;  pc_p2 <= 32'd0;  flg_p2 <= 8'd0;  va_p2 <= 32'd0;
        end else if (advance) begin
            // IF -> ID
            vld_p0 <= if_valid;
            pc_p0  <= if_pc;
            flg_p0 <= {1'b0, if_adef, 6'd0};
            va_p0  <= 32'd0;
            // ID -> EX
            vld_p1 <= vld_p0;
            pc_p1  <= pc_p0;
            flg_p1 <= merge_id_flags(flg_p0, id_ine, id_priv, plv_in,
                                     id_syscall, id_break, id_ertn);
            va_p1  <= va_p0;
            // EX -> WB
            vld_p2 <= vld_p1;
            pc_p2  <= pc_p1;
            flg_p2 <= merge_ex_flags(flg_p1, ale_take, vld_p1 && has_int_in);
            va_p2  <= ale_take ? ex_va : va_p1;
        end
    end

endmodule

// File: tb/tb_excp_ctrl.sv
// Directed bench for excp_ctrl: straight-line flow, fetch error, ALE with
// redirect back-pressure, AXI hold, IPE/interrupt and reset during redirect.
module tb_excp_ctrl;

    logic        clk;
    logic        reset;
    logic        stall, stallreq_axi;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_adef;
    logic        id_ine, id_priv, id_syscall, id_break, id_ertn;
    logic        ex_ale;
    logic [31:0] ex_va;
    logic        has_int_in;
    logic [1:0]  plv_in;
    logic        except_en;
    logic [31:0] new_pc;
    logic        wb_valid;
    logic [63:0] wb_csr_vec;
    logic [31:0] wb_pc, wb_error_va;
    logic        flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int checks = 0;
    int errors = 0;

    excp_ctrl #(.VEC_W(64)) dut (
        .clk(clk), .reset(reset), .stall(stall), .stallreq_axi(stallreq_axi),
        .if_valid(if_valid), .if_pc(if_pc), .if_adef(if_adef),
        .id_ine(id_ine), .id_priv(id_priv), .id_syscall(id_syscall),
        .id_break(id_break), .id_ertn(id_ertn),
        .ex_ale(ex_ale), .ex_va(ex_va), .has_int_in(has_int_in), .plv_in(plv_in),
        .except_en(except_en), .new_pc(new_pc),
        .wb_valid(wb_valid), .wb_csr_vec(wb_csr_vec), .wb_pc(wb_pc),
        .wb_error_va(wb_error_va), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; stallreq_axi = 0; if_valid = 0; if_pc = 0; if_adef = 0;
        id_ine = 0; id_priv = 0; id_syscall = 0; id_break = 0; id_ertn = 0;
        ex_ale = 0; ex_va = 0; has_int_in = 0; plv_in = 0;
        except_en = 0; new_pc = 0; redirect_ready = 0;
    endtask

    // Commit the WB exception and complete the redirect handshake.
    task automatic commit_and_return(input logic [31:0] tgt);
        except_en = 1; new_pc = tgt;
        tick();
        except_en = 0; redirect_ready = 1;
        tick();
        redirect_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        checks++;
        if (wb_valid !== 1'b0 || wb_csr_vec !== 64'd0 || wb_pc !== 32'd0 || wb_error_va !== 32'd0) begin
            errors++;
            $display("FAIL reset_wb: valid=%b vec=%h pc=%h va=%h, want all 0", wb_valid, wb_csr_vec, wb_pc, wb_error_va);
        end
        checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_redir: rv=%b rpc=%h flush=%b, want 0", redirect_valid, redirect_pc, flush);
        end
    endtask

    task automatic test_straight();
        logic        exp_v;
        logic [31:0] exp_pc;
        for (int c = 0; c < 8; c++) begin
            if_valid = (c < 4);
            if_pc    = 32'h1c000000 + 32'(4 * c);
            tick();
            exp_v  = (c >= 2) && (c - 2 < 4);
            exp_pc = 32'h1c000000 + 32'(4 * (c - 2));
            checks++;
            if (wb_valid !== exp_v || flush !== 1'b0 || (exp_v && (wb_pc !== exp_pc || wb_csr_vec !== 64'd0))) begin
                errors++;
                $display("FAIL straight_c%0d: valid=%b pc=%h vec=%h flush=%b, want valid=%b pc=%h vec=0 flush=0",
                         c, wb_valid, wb_pc, wb_csr_vec, flush, exp_v, exp_pc);
            end
        end
        idle_inputs();
    endtask

    task automatic test_adef();
        if_valid = 1; if_pc = 32'h1c000010; if_adef = 1;
        tick();
        if_valid = 0; if_adef = 0; id_syscall = 1;
        tick();
        id_syscall = 0; ex_ale = 1; ex_va = 32'h77;
        tick();
        ex_ale = 0; ex_va = 0;
        checks++;
        if (wb_valid !== 1'b1 || wb_csr_vec !== 64'h40 || wb_pc !== 32'h1c000010 || wb_error_va !== 32'd0) begin
            errors++;
            $display("FAIL adef_vec: valid=%b vec=%h pc=%h va=%h, want 1 40 1c000010 0", wb_valid, wb_csr_vec, wb_pc, wb_error_va);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b1 || wb_pc !== 32'h1c000010 || flush !== 1'b0) begin
            errors++;
            $display("FAIL adef_hold: valid=%b pc=%h flush=%b, want 1 1c000010 0", wb_valid, wb_pc, flush);
        end
        except_en = 1; new_pc = 32'h1c008000;
        #1;
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL adef_flush_comb: flush=%b, want 1", flush);
        end
        tick();
        except_en = 0; new_pc = 0;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c008000 || wb_valid !== 1'b0 || flush !== 1'b1) begin
            errors++;
            $display("FAIL adef_redirect: rv=%b rpc=%h wbv=%b flush=%b, want 1 1c008000 0 1", redirect_valid, redirect_pc, wb_valid, flush);
        end
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (wb_valid !== 1'b0 || redirect_valid !== 1'b0) begin
                errors++;
                $display("FAIL adef_drain_c%0d: wbv=%b rv=%b, want 0 0", c, wb_valid, redirect_valid);
            end
        end
    endtask

    task automatic test_ale_redirect();
        if_valid = 1; if_pc = 32'h1c000020;
        tick();
        if_valid = 0;
        tick();
        ex_ale = 1; ex_va = 32'h00000003;
        tick();
        ex_ale = 0; ex_va = 0;
        checks++;
        if (wb_csr_vec !== 64'h80 || wb_error_va !== 32'h3 || wb_pc !== 32'h1c000020) begin
            errors++;
            $display("FAIL ale_vec: vec=%h va=%h pc=%h, want 80 3 1c000020", wb_csr_vec, wb_error_va, wb_pc);
        end
        except_en = 1; new_pc = 32'h1c009000;
        tick();
        except_en = 0; new_pc = 32'h0badbad0;
        for (int c = 0; c < 5; c++) begin
            if_valid = 1; if_pc = 32'h1c0000f0;
            tick();
            checks++;
            if (redirect_valid !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h1c009000 || wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL ale_bp_c%0d: rv=%b flush=%b rpc=%h wbv=%b, want 1 1 1c009000 0", c, redirect_valid, flush, redirect_pc, wb_valid);
            end
        end
        // Handshake cycle: this fetch must be ignored.
        redirect_ready = 1; if_valid = 1; if_pc = 32'hdead0000;
        tick();
        redirect_ready = 0; if_pc = 32'h1c009000;
        tick();
        if_valid = 0; if_pc = 0;
        tick();
        checks++;
        if (wb_valid !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL ale_no_redir_fetch: wbv=%b rv=%b flush=%b, want 0 0 0", wb_valid, redirect_valid, flush);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b1 || wb_pc !== 32'h1c009000 || wb_csr_vec !== 64'd0) begin
            errors++;
            $display("FAIL ale_first_fetch: wbv=%b pc=%h vec=%h, want 1 1c009000 0", wb_valid, wb_pc, wb_csr_vec);
        end
        tick();
    endtask

    task automatic test_axi_stall();
        if_valid = 1; if_pc = 32'h1c000030;
        tick();
        if_pc = 32'h1c000034;
        tick();
        if_pc = 32'h1c000038; ex_ale = 1; ex_va = 32'h44;
        tick();
        if_valid = 0; ex_ale = 0; ex_va = 0;
        stallreq_axi = 1; except_en = 1; new_pc = 32'h1c00a000;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (flush !== 1'b0) begin
                errors++;
                $display("FAIL axi_flush_c%0d: flush=%b, want 0", c, flush);
            end
            tick();
            checks++;
            if (wb_pc !== 32'h1c000030 || wb_csr_vec !== 64'h80 || wb_error_va !== 32'h44 || redirect_valid !== 1'b0) begin
                errors++;
                $display("FAIL axi_hold_c%0d: pc=%h vec=%h va=%h rv=%b, want 1c000030 80 44 0", c, wb_pc, wb_csr_vec, wb_error_va, redirect_valid);
            end
        end
        // Drop the AXI stall together with a global stall: commit still wins.
        stallreq_axi = 0; stall = 1;
        #1;
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL axi_accept_flush: flush=%b, want 1", flush);
        end
        tick();
        stall = 0; except_en = 0;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c00a000 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL axi_redirect: rv=%b rpc=%h wbv=%b, want 1 1c00a000 0", redirect_valid, redirect_pc, wb_valid);
        end
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
    endtask

    task automatic test_ipe_int();
        if_valid = 1; if_pc = 32'h1c000040;
        tick();
        if_valid = 0; id_priv = 1; plv_in = 2'd3;
        tick();
        id_priv = 0; plv_in = 0;
        tick();
        checks++;
        if (wb_csr_vec !== 64'h20 || wb_pc !== 32'h1c000040) begin
            errors++;
            $display("FAIL ipe_vec: vec=%h pc=%h, want 20 1c000040", wb_csr_vec, wb_pc);
        end
        commit_and_return(32'h1c00b000);
        // Privileged op at PLV0 is legal; then an interrupt on the next one.
        if_valid = 1; if_pc = 32'h1c000050;
        tick();
        if_pc = 32'h1c000054; id_priv = 1; plv_in = 2'd0;
        tick();
        if_valid = 0; id_priv = 0;
        tick();
        checks++;
        if (wb_valid !== 1'b1 || wb_pc !== 32'h1c000050 || wb_csr_vec !== 64'd0) begin
            errors++;
            $display("FAIL plv0_vec: wbv=%b pc=%h vec=%h, want 1 1c000050 0", wb_valid, wb_pc, wb_csr_vec);
        end
        has_int_in = 1;
        tick();
        has_int_in = 0;
        checks++;
        if (wb_valid !== 1'b1 || wb_pc !== 32'h1c000054 || wb_csr_vec !== 64'h01) begin
            errors++;
            $display("FAIL int_vec: wbv=%b pc=%h vec=%h, want 1 1c000054 1", wb_valid, wb_pc, wb_csr_vec);
        end
        commit_and_return(32'h1c00c000);
    endtask

    task automatic test_reset_redir();
        if_valid = 1; if_pc = 32'h1c000060; if_adef = 1;
        tick();
        if_valid = 0; if_adef = 0;
        tick(); tick();
        except_en = 1; new_pc = 32'h1c00d000;
        tick();
        except_en = 0;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c00d000) begin
            errors++;
            $display("FAIL rr_enter: rv=%b rpc=%h, want 1 1c00d000", redirect_valid, redirect_pc);
        end
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (redirect_valid !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'd0 || wb_valid !== 1'b0 ||
            wb_csr_vec !== 64'd0 || wb_pc !== 32'd0 || wb_error_va !== 32'd0) begin
            errors++;
            $display("FAIL rr_reset: rv=%b flush=%b rpc=%h wbv=%b vec=%h pc=%h va=%h, want all 0",
                     redirect_valid, flush, redirect_pc, wb_valid, wb_csr_vec, wb_pc, wb_error_va);
        end
        if_valid = 1; if_pc = 32'h1c000070;
        tick();
        if_valid = 0;
        tick(); tick();
        checks++;
        if (wb_valid !== 1'b1 || wb_pc !== 32'h1c000070) begin
            errors++;
            $display("FAIL rr_run: wbv=%b pc=%h, want 1 1c000070", wb_valid, wb_pc);
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_adef();
        test_ale_redirect();
        test_axi_stall();
        test_ipe_int();
        test_reset_redir();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
